inst_fetch_unit: RTL and testbench

- Instruction fetch stage driven by the pipeline hazard controller; the controller's consumer end.
- Consumes fetch_stall, fetch_flush and the fetch_branch/fetch_branch_target redirect; produces fetch_done.
- Owns the PC, issues word reads to instruction memory through a req/ready + rvalid handshake, buffers one returned word and feeds the IF/ID register to decode.

---
 rtl/inst_fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage. Owns the PC, issues one word read at a time to
// instruction memory (req/ready accept, then rvalid return), buffers the
// returned word and hands it to the IF/ID register when the hazard controller
// lets the pipeline advance.
//
// Optional build macro: FETCH_MISALIGN_EN
//   defined   : a redirect to a target with addr[1:0] != 0 parks the unit in
//               FAULT (no requests, if_fault=1) until an aligned redirect.
//   undefined : no alignment check, pc[1:0] passes to imem_addr, if_fault=0.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_stall             hold IF/ID and buffer (memory side keeps moving)
//   fetch_flush             bubble into IF/ID
//   fetch_branch            redirect request (ignored while stalled)
//   fetch_branch_target     redirect PC
//   fetch_done              buffer holds a valid word for the current PC
//   imem_req / imem_addr    read request, address (always pc)
//   imem_ready              request accepted this cycle
//   imem_rvalid/imem_rdata  read data return
//   if_valid/if_pc/if_inst  IF/ID register towards decode
//   if_fault                misaligned fetch target (optional feature only)
// -----------------------------------------------------------------------------
// state  | meaning
// REQ    | request for pc driven, waiting for imem_ready
// WAIT   | request accepted, waiting for imem_rvalid
// DRAIN  | stale request outstanding, its data will be thrown away
// FULL   | buffer holds the word for pc, waiting to be consumed
// FAULT  | misaligned pc, idle until aligned redirect (optional feature)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_stall,
    input  logic                  fetch_flush,
    input  logic                  fetch_branch,
    input  logic [ADDR_WIDTH-1:0] fetch_branch_target,
    output logic                  fetch_done,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic                  if_fault
);

    // FAULT is only reachable when the misalignment check is built in.
    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FULL  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_load;
    logic                  redirect;
    logic                  consume;
    logic                  target_misaligned;
    logic                  pc_next_misaligned;

    // A stalled redirect is ignored; the controller re-presents it later.
    assign redirect = fetch_branch && !fetch_stall;
    assign consume  = (state == ST_FULL) && !fetch_stall && !fetch_flush && !fetch_branch;

`ifdef FETCH_MISALIGN_EN
    assign target_misaligned  = (fetch_branch_target[1:0] != 2'b00);
    assign pc_next_misaligned = (pc_next[1:0] != 2'b00);
`else
    assign target_misaligned  = 1'b0;
    assign pc_next_misaligned = 1'b0;
`endif

    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = fetch_branch_target;
        end else if (consume) begin
            pc_next = pc + ADDR_WIDTH'(4);
        end
    end

    always_comb begin
        state_next = state;
        buf_load   = 1'b0;
        case (state)
            ST_REQ: begin
                if (redirect) begin
                    // An accepted request for the old pc still has data coming.
                    if (imem_ready) begin
                        state_next = ST_DRAIN;
                    end else if (target_misaligned) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_REQ;
                    end
                end else if (imem_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    if (imem_rvalid) begin
                        state_next = target_misaligned ? ST_FAULT : ST_REQ;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    buf_load   = 1'b1;
                    state_next = ST_FULL;
                end
            end
            ST_DRAIN: begin
                // pc may have been redirected meanwhile; decide on its final value.
                if (imem_rvalid) begin
                    state_next = pc_next_misaligned ? ST_FAULT : ST_REQ;
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    state_next = target_misaligned ? ST_FAULT : ST_REQ;
                end else if (consume) begin
                    state_next = ST_REQ;
                end
            end
            ST_FAULT: begin
                if (redirect && !target_misaligned) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            buf_data   <= NOP_INST;
            fetch_done <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            fetch_done <= (state_next == ST_FULL);
            if (buf_load) begin
                buf_data <= imem_rdata;
            end
        end
    end

    // IF/ID register: flush beats stall, stall beats consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= NOP_INST;
        end else if (fetch_flush) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else if (fetch_stall) begin
            if_valid <= if_valid;
        end else if (consume) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_inst  <= buf_data;
        end else begin
            if_valid <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_fault <= 1'b0;
        end else if (redirect) begin
            if_fault <= target_misaligned;
        end
    end
`else
    assign if_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_stall;
    logic        fetch_flush;
    logic        fetch_branch;
    logic [31:0] fetch_branch_target;
    logic        fetch_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;

    int n_chk = 0;
    int n_err = 0;
    int mem_lat = 0;

    inst_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .NOP_INST   (32'h0000_0000)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_stall         (fetch_stall),
        .fetch_flush         (fetch_flush),
        .fetch_branch        (fetch_branch),
        .fetch_branch_target (fetch_branch_target),
        .fetch_done          (fetch_done),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .if_valid            (if_valid),
        .if_pc               (if_pc),
        .if_inst             (if_inst),
        .if_fault            (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observation point: just after the falling edge, inputs for the next
    // rising edge are driven from here.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return if_valid;
            1:       return fetch_done;
            2:       return imem_rvalid;
            default: return imem_req;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        for (int i = 0; i < 40 && !sel_val(sel); i++) step();
        chk({tag, "_timeout"}, {31'd0, sel_val(sel)}, 32'd1);
    endtask

    // Memory model: always accepts, returns 0x1111_0000+addr after mem_lat
    // extra cycles (0 = rvalid the cycle after acceptance).
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int          pend_cnt;
        pend        = 1'b0;
        pend_addr   = '0;
        pend_cnt    = 0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend       = 1'b0;
                imem_ready = 1'b0;
            end else begin
                imem_ready = 1'b1;
                if (pend) begin
                    if (pend_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = 32'h1111_0000 + pend_addr;
                        pend        = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end
                if (imem_req && imem_ready) begin
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    pend_cnt  = mem_lat;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n               = 1'b0;
        fetch_stall         = 1'b0;
        fetch_flush         = 1'b0;
        fetch_branch        = 1'b0;
        fetch_branch_target = '0;
        repeat (3) step();

        chk("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_if_valid",   {31'd0, if_valid},   32'd0);
        chk("rst_if_pc",      if_pc,               32'h0);
        chk("rst_if_inst",    if_inst,             32'h0);
        chk("rst_if_fault",   {31'd0, if_fault},   32'd0);
        chk("rst_imem_req",   {31'd0, imem_req},   32'd1);
        chk("rst_imem_addr",  imem_addr,           32'h0);
        rst_n = 1'b1;

        // Sequential fetch, zero-wait memory: one instruction every 3 cycles
        wait_for(0, "seq0");
        chk("seq0_pc",   if_pc,   32'h0);
        chk("seq0_inst", if_inst, 32'h1111_0000);
        chk("seq0_next_addr", imem_addr, 32'h4);
        step();
        chk("seq_bubble", {31'd0, if_valid}, 32'd0);
        step();
        chk("seq1_done", {31'd0, fetch_done}, 32'd1);
        step();
        chk("seq1_valid", {31'd0, if_valid}, 32'd1);
        chk("seq1_pc",    if_pc,   32'h4);
        chk("seq1_inst",  if_inst, 32'h1111_0004);

        // Stall while FULL at pc=0x8
        step();
        step();
        chk("st_pre_done", {31'd0, fetch_done}, 32'd1);
        chk("st_pre_addr", imem_addr, 32'h8);
        fetch_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("st_done", {31'd0, fetch_done}, 32'd1);
            chk("st_req",  {31'd0, imem_req},   32'd0);
            chk("st_pc",   if_pc,   32'h4);
            chk("st_inst", if_inst, 32'h1111_0004);
        end
        fetch_stall = 1'b0;
        step();
        chk("st_rel_valid", {31'd0, if_valid}, 32'd1);
        chk("st_rel_pc",    if_pc,   32'h8);
        chk("st_rel_inst",  if_inst, 32'h1111_0008);

        // Redirect while WAIT for pc=0x10 (slow return) -> DRAIN
        mem_lat = 3;
        step();
        step();
        step();
        chk("br_c_pc", if_pc, 32'hC);
        step();
        chk("br_wait_req",  {31'd0, imem_req}, 32'd0);
        chk("br_wait_addr", imem_addr, 32'h10);
        fetch_branch        = 1'b1;
        fetch_branch_target = 32'h40;
        step();
        fetch_branch = 1'b0;
        chk("br_drain_req",  {31'd0, imem_req}, 32'd0);
        chk("br_drain_addr", imem_addr, 32'h40);
        chk("br_drain_valid", {31'd0, if_valid}, 32'd0);
        mem_lat = 0;
        wait_for(3, "br_req");
        chk("br_req_addr",  imem_addr, 32'h40);
        chk("br_inst_hold", if_inst,   32'h1111_000C);
        wait_for(0, "br_tgt");
        chk("br_tgt_pc",   if_pc,   32'h40);
        chk("br_tgt_inst", if_inst, 32'h1111_0040);

        // Redirect to 0x80 in the same cycle as rvalid in WAIT
        wait_for(2, "bv_rvalid");
        chk("bv_wait_req", {31'd0, imem_req}, 32'd0);
        fetch_branch        = 1'b1;
        fetch_branch_target = 32'h80;
        step();
        fetch_branch = 1'b0;
        chk("bv_req",   {31'd0, imem_req},   32'd1);
        chk("bv_addr",  imem_addr,           32'h80);
        chk("bv_valid", {31'd0, if_valid},   32'd0);
        chk("bv_done",  {31'd0, fetch_done}, 32'd0);
        wait_for(0, "bv_tgt");
        chk("bv_tgt_pc",   if_pc,   32'h80);
        chk("bv_tgt_inst", if_inst, 32'h1111_0080);

        // Flush together with stall while if_valid=1
        fetch_stall = 1'b1;
        step();
        step();
        chk("fl_hold_valid", {31'd0, if_valid},   32'd1);
        chk("fl_pre_done",   {31'd0, fetch_done}, 32'd1);
        fetch_flush = 1'b1;
        step();
        chk("fl_valid", {31'd0, if_valid},   32'd0);
        chk("fl_inst",  if_inst,             32'h0);
        chk("fl_done",  {31'd0, fetch_done}, 32'd1);
        chk("fl_addr",  imem_addr,           32'h84);
        fetch_flush = 1'b0;
        fetch_stall = 1'b0;
        step();
        chk("fl_rel_valid", {31'd0, if_valid}, 32'd1);
        chk("fl_rel_pc",    if_pc,   32'h84);
        chk("fl_rel_inst",  if_inst, 32'h1111_0084);

        // Redirect from FULL to the top word, PC wraps to 0
        wait_for(1, "wr_full");
        fetch_branch        = 1'b1;
        fetch_branch_target = 32'hFFFF_FFFC;
        step();
        fetch_branch = 1'b0;
        chk("wr_done",  {31'd0, fetch_done}, 32'd0);
        chk("wr_req",   {31'd0, imem_req},   32'd1);
        chk("wr_addr",  imem_addr,           32'hFFFF_FFFC);
        chk("wr_valid", {31'd0, if_valid},   32'd0);
        wait_for(0, "wr_tgt");
        chk("wr_pc",        if_pc,     32'hFFFF_FFFC);
        chk("wr_inst",      if_inst,   32'h1110_FFFC);
        chk("wr_next_addr", imem_addr, 32'h0);

        // Misaligned redirect from FULL
        wait_for(1, "ma_full");
        fetch_branch        = 1'b1;
        fetch_branch_target = 32'h42;
        step();
        fetch_branch = 1'b0;
`ifdef FETCH_MISALIGN_EN
        chk("ma_fault", {31'd0, if_fault},   32'd1);
        chk("ma_req",   {31'd0, imem_req},   32'd0);
        chk("ma_done",  {31'd0, fetch_done}, 32'd0);
        repeat (3) step();
        chk("ma_fault_hold", {31'd0, if_fault}, 32'd1);
        chk("ma_req_hold",   {31'd0, imem_req}, 32'd0);
        fetch_branch        = 1'b1;
        fetch_branch_target = 32'h44;
        step();
        fetch_branch = 1'b0;
        chk("ma_clr",      {31'd0, if_fault}, 32'd0);
        chk("ma_clr_addr", imem_addr,         32'h44);
        chk("ma_clr_req",  {31'd0, imem_req}, 32'd1);
        wait_for(0, "ma_tgt");
        chk("ma_tgt_pc",   if_pc,   32'h44);
        chk("ma_tgt_inst", if_inst, 32'h1111_0044);
`else
        chk("ma_fault", {31'd0, if_fault}, 32'd0);
        chk("ma_req",   {31'd0, imem_req}, 32'd1);
        chk("ma_addr",  imem_addr,         32'h42);
        wait_for(0, "ma_tgt");
        chk("ma_tgt_pc",   if_pc,   32'h42);
        chk("ma_tgt_inst", if_inst, 32'h1111_0042);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
